// File: rtl/tone_envelope.sv
// ---------------------------------------------------------------------------
// tone_envelope
//
// Output stage behind the PWM tone modulator. The block applies a per-note
// ADSR amplitude envelope to the square tone and drives the 1-bit audio pin.
// The envelope amplitude sets the duty cycle of a 255-clock carrier PWM, and
// that PWM gates the tone.
//
// Optional feature (macro ENV_EXP_RELEASE_EN):
//   defined   : each RELEASE step subtracts max(1, amp>>4). This gives a
//               pseudo-exponential decay that saturates at 0.
//   undefined : each RELEASE step subtracts 1 (linear).
//
// Ports:
//   clk_i    in   system clock
//   rst_ni   in   synchronous, active-low reset
//   ena_i    in   global enable. When low, everything freezes and sound_o
//                 goes to 0.
//   strb_i   in   note-onset pulse. It (re)starts ATTACK and keeps the
//                 current amplitude.
//   gate_i   in   note-held level. Low starts RELEASE.
//   tone_i   in   square tone from the PWM modulator
//   mute_i   in   forces a silent output. The envelope keeps running.
//   sound_o  out  gated audio bit, registered (1 clk after tone_i)
//   amp_o    out  current envelope amplitude
//   state_o  out  IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy_o   out  high whenever state_o is not IDLE
// ---------------------------------------------------------------------------
module tone_envelope #(
   parameter int unsigned        AW          = 8,
   parameter int unsigned        DIV_BW      = 16,
   parameter logic [DIV_BW-1:0]  ATTACK_DIV  = 16'd188,
   parameter logic [DIV_BW-1:0]  DECAY_DIV   = 16'd376,
   parameter logic [AW-1:0]      SUSTAIN_LVL = 8'd160,
   parameter logic [DIV_BW-1:0]  RELEASE_DIV = 16'd752
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          ena_i,
   input  logic          strb_i,
   input  logic          gate_i,
   input  logic          tone_i,
   input  logic          mute_i,
   output logic          sound_o,
   output logic [AW-1:0] amp_o,
   output logic [2:0]    state_o,
   output logic          busy_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [AW-1:0] AMP_MAX = '1;
   // Common width for comparing the 8-bit carrier against the amplitude.
   localparam int CMPW = (AW > 8) ? AW : 8;

   state_t            state_q, state_d;
   logic [AW-1:0]     amp_q, amp_d;
   logic [DIV_BW-1:0] pre_q, pre_d;
   logic [7:0]        car_q, car_d;
   logic              sound_q, sound_d;

   logic [DIV_BW-1:0] div_sel;
   logic [DIV_BW-1:0] div_m1;
   logic              tc;
   logic              pwm;
   logic [AW-1:0]     rel_dec;
   logic [AW-1:0]     amp_rel;

   // Choose the prescaler divisor for the current state. A divisor of 0 or 1
   // produces one step per clock.
   always_comb begin
      div_sel = DIV_BW'(1);
      case (state_q)
         S_ATTACK:  div_sel = ATTACK_DIV;
         S_DECAY:   div_sel = DECAY_DIV;
         S_RELEASE: div_sel = RELEASE_DIV;
         default:   div_sel = DIV_BW'(1);
      endcase
      div_m1 = div_sel - DIV_BW'(1);
      tc     = (div_sel <= DIV_BW'(1)) || (pre_q >= div_m1);
   end

   // Compute the amount one RELEASE step subtracts. The result saturates at 0.
   always_comb begin
`ifdef ENV_EXP_RELEASE_EN
      rel_dec = amp_q >> 4;
      if (rel_dec == '0) begin
         rel_dec = AW'(1);
      end
`else
      rel_dec = AW'(1);
`endif
      amp_rel = (amp_q > rel_dec) ? (amp_q - rel_dec) : '0;
   end

   // The carrier runs 0..254, so amp=255 keeps pwm permanently high.
   assign pwm = (CMPW'(car_q) < CMPW'(amp_q));

   always_comb begin
      state_d = state_q;
      amp_d   = amp_q;
      pre_d   = pre_q;
      car_d   = car_q;
      sound_d = tone_i & pwm & ~mute_i & ena_i;

      if (ena_i) begin
         car_d = (car_q == 8'd254) ? 8'd0 : (car_q + 8'd1);
         pre_d = tc ? '0 : (pre_q + DIV_BW'(1));

         if (strb_i) begin
            // Retrigger. The current amplitude is kept so the output does
            // not click.
            state_d = S_ATTACK;
            pre_d   = '0;
         end else if (!gate_i && (state_q inside {S_ATTACK, S_DECAY, S_SUSTAIN})) begin
            state_d = S_RELEASE;
            pre_d   = '0;
         end else begin
            // A transition takes priority over a step in the same cycle.
            case (state_q)
               S_ATTACK: begin
                  if (amp_q == AMP_MAX) begin
                     state_d = S_DECAY;
                     pre_d   = '0;
                  end else if (tc) begin
                     amp_d = amp_q + AW'(1);
                  end
               end
               S_DECAY: begin
                  if (amp_q <= SUSTAIN_LVL) begin
                     state_d = S_SUSTAIN;
                     pre_d   = '0;
                  end else if (tc) begin
                     amp_d = amp_q - AW'(1);
                  end
               end
               S_RELEASE: begin
                  if (amp_q == '0) begin
                     state_d = S_IDLE;
                     pre_d   = '0;
                  end else if (tc) begin
                     amp_d = amp_rel;
                  end
               end
               S_IDLE, S_SUSTAIN: begin
                  pre_d = '0;
               end
               default: begin
                  state_d = S_IDLE;
                  pre_d   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         amp_q   <= '0;
         pre_q   <= '0;
         car_q   <= '0;
         sound_q <= 1'b0;
      end else begin
         state_q <= state_d;
         amp_q   <= amp_d;
         pre_q   <= pre_d;
         car_q   <= car_d;
         sound_q <= sound_d;
      end
   end

   assign sound_o = sound_q;
   assign amp_o   = amp_q;
   assign state_o = state_q;
   assign busy_o  = (state_q != S_IDLE);

endmodule
